// File: rtl/tqv_spi_reg_master.sv
// SPI mode-0 register-access initiator for the TinyQV peripheral harness.
// A frame is a 9-bit header {rw, txn_width, addr} sent MSB first. A write
// follows it with N data bits. A read follows it with READ_GAP dummy bits
// and then N bits captured from miso.
//
// Host handshake: start is sampled only while busy=0, and the request
// fields are latched on that cycle. From the next cycle busy stays 1 until
// the inter-frame gap ends. done pulses for one cycle on the cycle cs_n
// rises. On a read, rdata is already valid on that cycle.
//
// All outputs come from registers, so the SPI pins are glitch-free.
module tqv_spi_reg_master #(
    parameter int CLK_DIV  = 4,
    parameter int READ_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [1:0]  txn_width,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Header plus the widest write payload.
    localparam int TXW = 41;
    localparam int CW  = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // The GAP state lasts one cycle less than CLK_DIV. The IDLE cycle that
    // accepts the next start is still cs_n-high, so back-to-back frames are
    // separated by exactly CLK_DIV cycles.
    localparam logic [CW-1:0] GAP_LAST = CW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [5:0]       bits_q;
    logic [5:0]       n_q;
    logic             rw_q;
    logic [TXW-1:0]   tx_q;
    logic [31:0]      rx_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      rdata_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             mosi_q;

    logic [5:0]       n_d;
    logic [8:0]       hdr_d;
    logic [TXW-1:0]   tx_d;
    logic [5:0]       bits_d;

    // Build the frame image and bit count from the request fields.
    always_comb begin
        hdr_d = {rw, txn_width, addr};
        n_d   = 6'd32;
        tx_d  = {hdr_d, 32'h0};
        case (txn_width)
            2'b00:   n_d = 6'd8;
            2'b01:   n_d = 6'd16;
            default: n_d = 6'd32;
        endcase
        if (rw) begin
            case (txn_width)
                2'b00:   tx_d = {hdr_d, wdata[7:0], 24'h0};
                2'b01:   tx_d = {hdr_d, wdata[15:0], 16'h0};
                default: tx_d = {hdr_d, wdata};
            endcase
        end
        bits_d = rw ? (6'd9 + n_d) : (6'(9 + READ_GAP) + n_d);
    end

    // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            n_q     <= '0;
            rw_q    <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        n_q     <= n_d;
                        // The first bit goes straight to mosi. tx_q holds
                        // the bits still to be sent.
                        mosi_q  <= tx_d[TXW-1];
                        tx_q    <= {tx_d[TXW-2:0], 1'b0};
                        bits_q  <= bits_d;
                        rx_q    <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= DIV_LAST;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= DIV_LAST;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q <= DIV_LAST;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // End of the high phase: sample miso, drop
                            // SCLK and present the next bit together.
                            sclk_q <= 1'b0;
                            if (!rw_q && (bits_q <= n_q)) begin
                                rx_q <= {rx_q[30:0], spi_miso};
                            end
                            if (bits_q == 6'd1) begin
                                mosi_q  <= 1'b0;
                                state_q <= HOLD;
                            end else begin
                                bits_q <= bits_q - 1'b1;
                                mosi_q <= tx_q[TXW-1];
                                tx_q   <= {tx_q[TXW-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        if (!rw_q) begin
                            rdata_q <= rx_q;
                        end
                        cnt_q   <= GAP_LAST;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_tqv_spi_reg_master.sv
// Self-checking bench for tqv_spi_reg_master.
// A negedge monitor records each frame's mosi bits, rising SCLK count and
// cs_n low time. A responder model drives read data on miso.
module tb_tqv_spi_reg_master;

    localparam int READ_GAP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rw;
    logic [1:0]  tw;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    tqv_spi_reg_master #(.CLK_DIV(4), .READ_GAP(READ_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rw        (rw),
        .txn_width (tw),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    // Clock.
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Frame monitor, sampled on the negedge away from the active edge.
    logic        prev_cs    = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        prev_mosi  = 1'b0;
    int          cur_low    = 0;
    int          cur_rises  = 0;
    int          cur_falls  = 0;
    logic [63:0] cur_cap    = '0;
    int          last_low   = 0;
    int          last_rises = 0;
    logic [63:0] last_cap   = '0;
    int          mosi_viol  = 0;

    always @(negedge clk) begin
        prev_cs   <= spi_cs_n;
        prev_sclk <= spi_clk;
        prev_mosi <= spi_mosi;
        if (!spi_cs_n) begin
            if (prev_cs) begin
                cur_low   <= 1;
                cur_rises <= 0;
                cur_falls <= 0;
                cur_cap   <= '0;
            end else begin
                cur_low <= cur_low + 1;
                if (spi_clk && !prev_sclk) begin
                    cur_rises <= cur_rises + 1;
                    cur_cap   <= {cur_cap[62:0], spi_mosi};
                end
                if (!spi_clk && prev_sclk) cur_falls <= cur_falls + 1;
                if ((spi_mosi !== prev_mosi) && !(prev_sclk && !spi_clk)) mosi_viol <= mosi_viol + 1;
            end
        end else if (!prev_cs) begin
            last_low   <= cur_low;
            last_rises <= cur_rises;
            last_cap   <= cur_cap;
        end
    end

    // Responder: data bit k is presented after 9+READ_GAP+k falling edges.
    int          resp_n    = 8;
    logic [31:0] resp_data = '0;
    int          m_idx;
    always_comb begin
        m_idx    = cur_falls - 9 - READ_GAP;
        spi_miso = 1'b0;
        if (!spi_cs_n && m_idx >= 0 && m_idx < resp_n) spi_miso = resp_data[resp_n-1-m_idx];
    end

    function automatic int width_of(input logic [1:0] w);
        return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    endfunction

    // Driver: one transaction, bounded waits.
    task automatic do_frame(input logic r, input logic [1:0] w, input logic [5:0] a,
                            input logic [31:0] d, input logic [31:0] resp,
                            output logic [31:0] rd_at_done, output int dones);
        logic got;
        resp_n     = width_of(w);
        resp_data  = resp;
        rd_at_done = rdata;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        @(negedge clk);
        rw = r; tw = w; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        got   = 1'b0;
        for (int i = 0; i < 3000 && !(got && !busy); i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                rd_at_done = rdata;
                got = 1'b1;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  tw;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        logic [63:0] exp_frame;
        int          exp_bits;
        int          exp_low;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] rd;
        int          dn;
        int          gap;
        logic [31:0] model_rd;

        vecs[0] = '{1'b1, 2'b00, 6'h05, 32'h0000_00A5, 32'h0,         64'h1_05A5,              17, 144, 32'h0};
        vecs[1] = '{1'b0, 2'b10, 6'h3F, 32'h0,         32'hDEAD_BEEF, 64'h0000_BF00_0000_0000, 49, 400, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 2'b01, 6'h12, 32'h0,         32'h0000_1234, 64'h0000_0000_5200_0000, 33, 272, 32'h0000_1234};
        vecs[3] = '{1'b1, 2'b01, 6'h2A, 32'hFFFF_BEEF, 32'h0,         64'h016A_BEEF,           25, 208, 32'h0000_1234};
        vecs[4] = '{1'b1, 2'b11, 6'h00, 32'h8000_0001, 32'h0,         64'h0000_01C0_8000_0001, 41, 336, 32'h0000_1234};
        vecs[5] = '{1'b0, 2'b00, 6'h01, 32'h0,         32'h0000_005A, 64'h0001_0000,           25, 208, 32'h0000_005A};

        // Reset, with a start pulse that must be ignored.
        rst = 1'b1; start = 1'b0; rw = 1'b0; tw = 2'b00; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cs_n", spi_cs_n, 1'b1);
        check("reset_sclk", spi_clk, 1'b0);
        check("reset_mosi", spi_mosi, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rdata", rdata, 32'h0);

        // Abort mid-SHIFT with asynchronous reset.
        @(negedge clk);
        rw = 1'b1; tw = 2'b10; addr = 6'h11; wdata = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);
        for (int i = 0; i < 20 && !spi_clk; i++) @(negedge clk);
        check("abort_mid_high", spi_clk, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sclk", spi_clk, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        check("abort_rdata", rdata, 32'h0);

        // Table-driven directed frames.
        for (int v = 0; v < 6; v++) begin
            do_frame(vecs[v].rw, vecs[v].tw, vecs[v].addr, vecs[v].wdata, vecs[v].resp, rd, dn);
            check($sformatf("v%0d_frame", v), last_cap, vecs[v].exp_frame);
            check($sformatf("v%0d_rises", v), last_rises, vecs[v].exp_bits);
            check($sformatf("v%0d_cs_low", v), last_low, vecs[v].exp_low);
            check($sformatf("v%0d_done_cnt", v), dn, 1);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
        end

        // start held high: back-to-back frames; fields changed while busy.
        @(negedge clk);
        resp_n = 8;
        rw = 1'b1; tw = 2'b00; addr = 6'h05; wdata = 32'h0000_00A5; start = 1'b1;
        @(negedge clk);
        rw = 1'b1; tw = 2'b00; addr = 6'h0A; wdata = 32'h0000_003C;
        for (int i = 0; i < 400 && !spi_cs_n; i++) @(negedge clk);
        gap = 0;
        while (spi_cs_n && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_gap", gap, 4);
        check("b2b_frame1", last_cap, 64'h1_05A5);
        for (int i = 0; i < 400 && !spi_cs_n; i++) @(negedge clk);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("b2b_frame2", last_cap, 64'h1_0A3C);
        check("b2b_idle", busy, 1'b0);

        // Random transactions against a small frame model.
        model_rd = 32'h0000_005A;
        for (int t = 0; t < 4; t++) begin
            logic        r;
            logic [1:0]  w;
            logic [5:0]  a;
            logic [31:0] d, rs, mask;
            logic [63:0] hdr, exp_f;
            int          n;
            r  = 1'($urandom_range(0, 1));
            w  = 2'($urandom_range(0, 3));
            a  = 6'($urandom_range(0, 63));
            d  = $urandom;
            rs = $urandom;
            n  = width_of(w);
            mask  = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 1);
            hdr   = {55'h0, r, w, a};
            exp_f = r ? ((hdr << n) | {32'h0, d & mask}) : (hdr << (READ_GAP + n));
            if (!r) model_rd = rs & mask;
            do_frame(r, w, a, d, rs, rd, dn);
            check($sformatf("rnd%0d_frame", t), last_cap, exp_f);
            check($sformatf("rnd%0d_rdata", t), rd, model_rd);
        end

        check("mosi_stable_on_rise", mosi_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
